// File: rtl/cpu_defs.sv
// cpu_defs: shared next-PC select encodings and fixed kernel vectors.
package cpu_defs;
    localparam logic [2:0] PCSRC_SEQ   = 3'd0;
    localparam logic [2:0] PCSRC_BR    = 3'd1;
    localparam logic [2:0] PCSRC_J     = 3'd2;
    localparam logic [2:0] PCSRC_JR    = 3'd3;
    localparam logic [2:0] PCSRC_ILLOP = 3'd4;
    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam logic [31:0] ILLOP_VEC = 32'h8000_0004;
    localparam logic [31:0] XADR_VEC  = 32'h8000_0008;
    typedef enum logic {IDLE, PEND} int_state_t;
endpackage

// File: rtl/irq_sync.sv
// irq_sync: two-flop synchroniser for an asynchronous level input.
module irq_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or negedge reset)
        if (!reset) {q, m} <= 2'b00;
        else        {q, m} <= {m, d};
endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with branch/jump/jr/exception select, kernel-mode
// tracking in PC[31], EPC capture and latched interrupt entry.
module pc_unit
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic [2:0]  PCSrc,
    input  logic        BranchTaken,
    input  logic [31:0] ConBA,
    input  logic [25:0] JT,
    input  logic [31:0] DataBusA,
    input  logic        IRQ,
    output logic [31:0] PC,
    output logic [31:0] PCplus4,
    output logic [31:0] EPC,
    output logic        IntTaken
);
    int_state_t  state;
    logic        irq_s, illop, take;
    logic [31:0] cand;

    irq_sync u_sync (.clk(clk), .reset(reset), .d(IRQ), .q(irq_s));

    assign PCplus4 = {PC[31], PC[30:0] + 31'd4};
    // user-mode jr cannot set bit 31, so only kernel code can stay in kernel
    assign cand = (PCSrc == PCSRC_BR && BranchTaken) ? {PC[31], ConBA[30:0]} :
                  (PCSrc == PCSRC_J)     ? {PC[31], PCplus4[30:28], JT, 2'b00} :
                  (PCSrc == PCSRC_JR)    ? {PC[31] & DataBusA[31], DataBusA[30:0]} :
                  (PCSrc == PCSRC_ILLOP) ? ILLOP_VEC : PCplus4;
    assign illop    = PCSrc == PCSRC_ILLOP;
    assign take     = state == PEND && !PC[31] && !Stall && !illop;
    assign IntTaken = take;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            PC    <= RESET_PC;
            EPC   <= '0;
            state <= IDLE;
        end else begin
            if (!Stall) begin
                PC  <= take ? XADR_VEC : cand;
                EPC <= take ? cand : illop ? PCplus4 : EPC;
            end
            state <= take ? IDLE : irq_s ? PEND : state;
        end
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Program-counter stage of the single-cycle MIPS CPU.
- Holds PC and produces PCplus4 for the immediate-extension unit and the ALU path.
- Consumes the branch target ConBA returned by that unit.
- Selects the next PC among sequential, branch, jump, jump-register and exception/interrupt vectors, tracks kernel mode in PC[31], captures EPC, and synchronises an external interrupt request.

Parameters:
- RESET_PC, 32'h8000_0000, PC after reset (kernel entry).
- ILLOP_VEC, 32'h8000_0004, illegal-instruction / exception vector.
- XADR_VEC, 32'h8000_0008, interrupt vector.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Stall  in  1  hold PC and EPC this cycle.
- PCSrc  in  3  next-PC select: 0 seq, 1 branch, 2 jump, 3 jr, 4 illop.
- BranchTaken  in  1  branch condition from ALU; used only when PCSrc=1.
- ConBA  in  32  branch target from the extension unit.
- JT  in  26  instruction[25:0] jump field.
- DataBusA  in  32  rs register value for jr/jalr.
- IRQ  in  1  asynchronous external interrupt request, level.
- PC  out  32  current instruction address.
- PCplus4  out  32  PC+4, with PC[31] preserved.
- EPC  out  32  exception return address.
- IntTaken  out  1  one-cycle pulse; the edge ending this cycle loads XADR_VEC.

Behaviour:
- Reset (reset=0, asynchronous): PC=RESET_PC, EPC=0, IRQ synchroniser flops=0, int state=IDLE, IntTaken=0.
- PCplus4 is combinational: {PC[31], PC[30:0]+31'd4}. Carry out of bit 30 is discarded; bit 31 is never altered.
- Candidate next PC (cand):
  - PCSrc=0: PCplus4.
  - PCSrc=1: ConBA if BranchTaken, else PCplus4; bit31 forced to PC[31].
  - PCSrc=2: {PC[31], PCplus4[30:28], JT, 2'b00}.
  - PCSrc=3: DataBusA if PC[31]=1. In user mode (PC[31]=0) bit31 forced 0 and bits[30:0] from DataBusA.
  - PCSrc=4: ILLOP_VEC.
  - PCSrc=5..7: PCplus4 (reserved).
- IRQ path: two-flop synchroniser giving irq_s, which is 2 cycles of latency from IRQ. Int FSM has states IDLE and PEND.
  - IDLE -> PEND when irq_s=1.
  - PEND -> IDLE when the interrupt is taken.
  - Entering PEND is allowed in any mode; taking the interrupt is allowed only when PC[31]=0.
- Take condition: state=PEND, PC[31]=0, Stall=0, PCSrc!=4. When true:
  - IntTaken=1 combinationally.
  - At the edge: PC<=XADR_VEC, EPC<=cand (the current instruction completes), state<=IDLE.
- Exception (PCSrc=4, Stall=0): PC<=ILLOP_VEC, EPC<=PCplus4. The exception has priority over a pending interrupt, which stays in PEND.
- Normal cycle (Stall=0, no take, PCSrc!=4): PC<=cand, EPC unchanged.
- Stall=1: PC, EPC and IntTaken=0 held. The synchroniser and the IDLE->PEND transition still advance.
- In kernel mode (PC[31]=1) PEND is held until a jr with DataBusA[31]=0 returns to user mode. The interrupt is taken on the first non-stalled user-mode cycle after that.
- irq_s dropping while in PEND does not cancel PEND (latched request).
- Reset asserted mid-stall or mid-PEND: all state returns to reset values immediately.

Decomposition:
- Shared package (cpu_defs): PCSrc encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_J, PCSRC_JR, PCSRC_ILLOP), RESET_PC, ILLOP_VEC, XADR_VEC.
- One sub-module: irq_sync, a 2-flop synchroniser (clk, reset, async in, sync out). It is reused elsewhere in the design.

Test Plan:
- Reset release, PCSrc=0, 3 cycles: PC 8000_0000 -> 8000_0004 -> 8000_0008 -> 8000_000C; EPC=0.
- PC=0000_0100, PCSrc=1, ConBA=0000_0040: BranchTaken=1 -> PC=0000_0040; BranchTaken=0 -> PC=0000_0104.
- PC=0040_0000, PCSrc=2, JT=26'h0000010 -> PC=0000_0040. PC=0000_0010, PCSrc=3, DataBusA=8000_1234 -> PC=0000_1234 (user cannot enter kernel).
- PC=0000_0200, PCSrc=4 -> PC=8000_0004, EPC=0000_0204. Stall=1 the following cycle -> PC and EPC unchanged.
- PC=0000_0300 in user mode, PCSrc=0, IRQ pulsed high for 1 cycle:
  - PEND reached 2 cycles later.
  - On the next non-stalled cycle IntTaken=1, PC->8000_0008, EPC = the PC+4 of that cycle.
  - With IRQ raised while PC=8000_0010 (kernel), no take until jr to 0000_0500. The cycle after PC=0000_0500, PC=8000_0008 and EPC=0000_0504.
- PEND and PCSrc=4 in the same cycle: PC=8000_0004 and PEND retained. The next user-mode non-stalled cycle takes the interrupt.
